// File: rtl/pt_axi4lite_initiator.sv
// Single-outstanding AXI4-Lite manager bridging a simple valid/ready request/response port.
// Optional error counter (i_err_clear / o_err_count) when PT_AXI4LITE_INIT_ERR_CNT_EN is defined.
module pt_axi4lite_initiator #(
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 64,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
`ifdef PT_AXI4LITE_INIT_ERR_CNT_EN
    input  logic              i_err_clear,
    output logic [7:0]        o_err_count,
`endif
    output logic              o_idle,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_write,
    input  logic [DATA_W-1:0] i_req_wdata,
    input  logic [STRB_W-1:0] i_req_wstrb,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] o_rsp_rdata,
    output logic              o_rsp_error,
    output logic [ADDR_W-1:0] o_awaddr,
    output logic [2:0]        o_awprot,
    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [DATA_W-1:0] o_wdata,
    output logic [STRB_W-1:0] o_wstrb,
    output logic              o_wvalid,
    input  logic              i_wready,
    input  logic [1:0]        i_bresp,
    input  logic              i_bvalid,
    output logic              o_bready,
    output logic [ADDR_W-1:0] o_araddr,
    output logic [2:0]        o_arprot,
    output logic              o_arvalid,
    input  logic              i_arready,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rvalid,
    output logic              o_rready
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RSP, RD_REQ, RD_RSP, RSP_HOLD} state_t;

    state_t            state_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;
    logic [STRB_W-1:0] wstrb_reg;
    logic [DATA_W-1:0] rdata_reg;
    logic              rsp_error_reg;
    logic              rsp_valid_reg;
    logic              idle_reg;
    logic              awvalid_reg;
    logic              wvalid_reg;
    logic              bready_reg;
    logic              arvalid_reg;
    logic              rready_reg;

    // A channel is still outstanding after this edge if it is valid and not accepted now.
    logic aw_left;
    logic w_left;
    assign aw_left = awvalid_reg & ~i_awready;
    assign w_left  = wvalid_reg & ~i_wready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            rdata_reg     <= '0;
            rsp_error_reg <= 1'b0;
            rsp_valid_reg <= 1'b0;
            idle_reg      <= 1'b1;
            awvalid_reg   <= 1'b0;
            wvalid_reg    <= 1'b0;
            bready_reg    <= 1'b0;
            arvalid_reg   <= 1'b0;
            rready_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_req_valid) begin
                        addr_reg  <= i_req_addr;
                        wdata_reg <= i_req_wdata;
                        wstrb_reg <= i_req_wstrb;
                        idle_reg  <= 1'b0;
                        if (i_req_write) begin
                            awvalid_reg <= 1'b1;
                            wvalid_reg  <= 1'b1;
                            state_reg   <= WR_REQ;
                        end else begin
                            arvalid_reg <= 1'b1;
                            state_reg   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    awvalid_reg <= aw_left;
                    wvalid_reg  <= w_left;
                    if (!aw_left && !w_left) begin
                        bready_reg <= 1'b1;
                        state_reg  <= WR_RSP;
                    end
                end
                WR_RSP: begin
                    if (i_bvalid) begin
                        bready_reg    <= 1'b0;
                        rdata_reg     <= '0;
                        rsp_error_reg <= i_bresp[1];
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RSP_HOLD;
                    end
                end
                RD_REQ: begin
                    if (i_arready) begin
                        arvalid_reg <= 1'b0;
                        rready_reg  <= 1'b1;
                        state_reg   <= RD_RSP;
                    end
                end
                RD_RSP: begin
                    if (i_rvalid) begin
                        rready_reg    <= 1'b0;
                        rdata_reg     <= i_rdata;
                        rsp_error_reg <= i_rresp[1];
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RSP_HOLD;
                    end
                end
                RSP_HOLD: begin
                    if (i_rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        idle_reg      <= 1'b1;
                        state_reg     <= IDLE;
                    end
                end
                default: begin
                    idle_reg  <= 1'b1;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef PT_AXI4LITE_INIT_ERR_CNT_EN
    // Counted when an erroring response is captured, i.e. as it is issued.
    logic       err_event;
    logic [7:0] err_count_reg;
    assign err_event = ((state_reg == WR_RSP) && i_bvalid && i_bresp[1]) ||
                       ((state_reg == RD_RSP) && i_rvalid && i_rresp[1]);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_count_reg <= 8'd0;
        end else if (i_err_clear) begin
            err_count_reg <= 8'd0;
        end else if (err_event && (err_count_reg != 8'hFF)) begin
            err_count_reg <= err_count_reg + 8'd1;
        end
    end
    assign o_err_count = err_count_reg;
`endif

    assign o_idle      = idle_reg;
    assign o_req_ready = idle_reg;
    assign o_rsp_valid = rsp_valid_reg;
    assign o_rsp_rdata = rdata_reg;
    assign o_rsp_error = rsp_error_reg;
    assign o_awaddr    = addr_reg;
    assign o_awprot    = 3'b000;
    assign o_awvalid   = awvalid_reg;
    assign o_wdata     = wdata_reg;
    assign o_wstrb     = wstrb_reg;
    assign o_wvalid    = wvalid_reg;
    assign o_bready    = bready_reg;
    assign o_araddr    = addr_reg;
    assign o_arprot    = 3'b000;
    assign o_arvalid   = arvalid_reg;
    assign o_rready    = rready_reg;
endmodule

// File: tb/tb_pt_axi4lite_initiator.sv
// Randomized bench: a cycle-stepped AXI4-Lite peer plus a transaction-level expectation model.
module tb_pt_axi4lite_initiator;
    logic        i_clk;
    logic        i_rst;
    logic        o_idle;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        i_req_write;
    logic [63:0] i_req_wdata;
    logic [7:0]  i_req_wstrb;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [63:0] o_rsp_rdata;
    logic        o_rsp_error;
    logic [31:0] o_awaddr;
    logic [2:0]  o_awprot;
    logic        o_awvalid;
    logic        i_awready;
    logic [63:0] o_wdata;
    logic [7:0]  o_wstrb;
    logic        o_wvalid;
    logic        i_wready;
    logic [1:0]  i_bresp;
    logic        i_bvalid;
    logic        o_bready;
    logic [31:0] o_araddr;
    logic [2:0]  o_arprot;
    logic        o_arvalid;
    logic        i_arready;
    logic [63:0] i_rdata;
    logic [1:0]  i_rresp;
    logic        i_rvalid;
    logic        o_rready;
`ifdef PT_AXI4LITE_INIT_ERR_CNT_EN
    logic        i_err_clear;
    logic [7:0]  o_err_count;
`endif

    int checks   = 0;
    int failures = 0;
    int model_err_cnt = 0;

    pt_axi4lite_initiator dut (
        .i_clk(i_clk), .i_rst(i_rst),
`ifdef PT_AXI4LITE_INIT_ERR_CNT_EN
        .i_err_clear(i_err_clear), .o_err_count(o_err_count),
`endif
        .o_idle(o_idle), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_addr(i_req_addr), .i_req_write(i_req_write),
        .i_req_wdata(i_req_wdata), .i_req_wstrb(i_req_wstrb),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_error(o_rsp_error),
        .o_awaddr(o_awaddr), .o_awprot(o_awprot), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_araddr(o_araddr), .o_arprot(o_arprot), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // One complete transaction; entered and left on a falling edge with the DUT idle.
    // aw_d: AW (or AR) acceptance delay, w_d: W delay, bd: B/R delay after the address phase.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [63:0] wd,
                           input logic [7:0] ws, input int aw_d, input int w_d, input int bd,
                           input logic [1:0] resp, input logic [63:0] rd, input int hold_d,
                           input bit do_clr);
        int t = 1;
        int aw_cnt = 0;
        int w_cnt = 0;
        int b_wait = 0;
        bit aw_done = 0;
        bit w_done = 0;
        bit d_done = 0;
        bit aw_fire;
        bit w_fire;
        logic [63:0] exp_rd;
        logic        exp_err;
        exp_rd  = wr ? 64'h0 : rd;
        exp_err = resp[1];

        chk("req_ready_idle", o_req_ready, 1'b1);
        chk("idle_before", o_idle, 1'b1);
        i_req_valid = 1'b1;
        i_req_write = wr;
        i_req_addr  = addr;
        i_req_wdata = wd;
        i_req_wstrb = ws;
        @(negedge i_clk);
        // Scramble the request bus so the registered copy is what gets checked.
        i_req_valid = 1'b0;
        i_req_addr  = $urandom;
        i_req_wdata = {$urandom, $urandom};
        i_req_wstrb = 8'($urandom);
        i_req_write = 1'($urandom);

        while (!d_done && t < 64) begin
            aw_fire = 1'b0;
            w_fire  = 1'b0;
            chk("req_ready_busy", o_req_ready, 1'b0);
            chk("idle_busy", o_idle, 1'b0);
            chk("rsp_valid_busy", o_rsp_valid, 1'b0);
            chk("prot", {o_awprot, o_arprot}, 6'b0);
            if (wr) begin
                chk("arvalid_wr", o_arvalid, 1'b0);
                chk("rready_wr", o_rready, 1'b0);
                if (!aw_done) begin
                    chk("awvalid", o_awvalid, 1'b1);
                    chk("awaddr", o_awaddr, addr);
                    aw_fire = (aw_cnt >= aw_d);
                    aw_cnt++;
                    i_awready = aw_fire;
                end else begin
                    chk("awvalid_done", o_awvalid, 1'b0);
                    i_awready = 1'($urandom);
                end
                if (!w_done) begin
                    chk("wvalid", o_wvalid, 1'b1);
                    chk("wdata", o_wdata, wd);
                    chk("wstrb", o_wstrb, ws);
                    w_fire = (w_cnt >= w_d);
                    w_cnt++;
                    i_wready = w_fire;
                end else begin
                    chk("wvalid_done", o_wvalid, 1'b0);
                    i_wready = 1'($urandom);
                end
                if (aw_done && w_done) begin
                    chk("bready", o_bready, 1'b1);
                    i_bvalid = (b_wait >= bd);
                    i_bresp  = i_bvalid ? resp : 2'($urandom);
                    d_done   = i_bvalid;
                    b_wait++;
                end else begin
                    chk("bready_early", o_bready, 1'b0);
                    i_bvalid = 1'($urandom);
                    i_bresp  = 2'($urandom);
                end
                aw_done = aw_done | aw_fire;
                w_done  = w_done | w_fire;
                i_rvalid = 1'($urandom);
                i_rdata  = {$urandom, $urandom};
                i_rresp  = 2'($urandom);
            end else begin
                chk("awvalid_rd", o_awvalid, 1'b0);
                chk("wvalid_rd", o_wvalid, 1'b0);
                chk("bready_rd", o_bready, 1'b0);
                if (!aw_done) begin
                    chk("arvalid", o_arvalid, 1'b1);
                    chk("araddr", o_araddr, addr);
                    aw_fire = (aw_cnt >= aw_d);
                    aw_cnt++;
                    i_arready = aw_fire;
                end else begin
                    chk("arvalid_done", o_arvalid, 1'b0);
                    i_arready = 1'($urandom);
                end
                if (aw_done) begin
                    chk("rready", o_rready, 1'b1);
                    i_rvalid = (b_wait >= bd);
                    i_rdata  = i_rvalid ? rd : {$urandom, $urandom};
                    i_rresp  = i_rvalid ? resp : 2'($urandom);
                    d_done   = i_rvalid;
                    b_wait++;
                end else begin
                    chk("rready_early", o_rready, 1'b0);
                    i_rvalid = 1'($urandom);
                    i_rdata  = {$urandom, $urandom};
                    i_rresp  = 2'($urandom);
                end
                aw_done  = aw_done | aw_fire;
                i_bvalid = 1'($urandom);
                i_bresp  = 2'($urandom);
            end
`ifdef PT_AXI4LITE_INIT_ERR_CNT_EN
            i_err_clear = d_done & do_clr;
`endif
            @(negedge i_clk);
            t++;
        end
        chk("rsp_timeout", d_done, 1'b1);
        if (aw_d == 0 && w_d == 0 && bd == 0)
            chk("latency_rsp", t, 3);
        if (do_clr) model_err_cnt = 0;
        else if (exp_err && model_err_cnt < 255) model_err_cnt++;
`ifdef PT_AXI4LITE_INIT_ERR_CNT_EN
        i_err_clear = 1'b0;
`endif

        // Response hold: junk B/R traffic must not disturb the captured response.
        for (int k = 0; k <= hold_d; k++) begin
            chk("rsp_valid", o_rsp_valid, 1'b1);
            chk("rsp_rdata", o_rsp_rdata, exp_rd);
            chk("rsp_error", o_rsp_error, exp_err);
            chk("req_ready_hold", o_req_ready, 1'b0);
            chk("readies_hold", {o_bready, o_rready}, 2'b0);
            chk("valids_hold", {o_awvalid, o_wvalid, o_arvalid}, 3'b0);
            i_rsp_ready = (k == hold_d);
            i_bvalid = 1'b1;
            i_bresp  = 2'($urandom);
            i_rvalid = 1'b1;
            i_rdata  = {$urandom, $urandom};
            i_rresp  = 2'($urandom);
            @(negedge i_clk);
        end
        i_rsp_ready = 1'b0;
        chk("rsp_valid_after", o_rsp_valid, 1'b0);
        chk("req_ready_after", o_req_ready, 1'b1);
`ifdef PT_AXI4LITE_INIT_ERR_CNT_EN
        chk("err_count", o_err_count, 8'(model_err_cnt));
`endif
    endtask

    initial begin
        i_rst = 1'b1;
        i_req_valid = 0; i_req_addr = 0; i_req_write = 0; i_req_wdata = 0; i_req_wstrb = 0;
        i_rsp_ready = 0; i_awready = 0; i_wready = 0; i_bresp = 0; i_bvalid = 0;
        i_arready = 0; i_rdata = 0; i_rresp = 0; i_rvalid = 0;
`ifdef PT_AXI4LITE_INIT_ERR_CNT_EN
        i_err_clear = 0;
`endif
        repeat (3) @(negedge i_clk);
        chk("rst_idle", o_idle, 1'b1);
        chk("rst_req_ready", o_req_ready, 1'b1);
        chk("rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_rsp_valid}, 4'b0);
        chk("rst_readies", {o_bready, o_rready}, 2'b0);
        chk("rst_payload", {o_awaddr, o_wstrb, o_rsp_error}, 41'b0);
        chk("rst_wdata", o_wdata, 64'h0);
        chk("rst_rdata", o_rsp_rdata, 64'h0);
`ifdef PT_AXI4LITE_INIT_ERR_CNT_EN
        chk("rst_err_count", o_err_count, 8'd0);
`endif
        i_rst = 1'b0;
        @(negedge i_clk);

        // Directed cases with literal expectations.
        run_txn(1, 32'h40, 64'h1122334455667788, 8'hFF, 0, 0, 0, 2'b00, 64'h0, 0, 0);
        run_txn(1, 32'h44, 64'hA5A5_5A5A_0F0F_F0F0, 8'h0F, 0, 3, 0, 2'b00, 64'h0, 1, 0);
        run_txn(0, 32'h80, 64'hDEADBEEF, 8'h00, 0, 0, 0, 2'b10, 64'hDEADBEEF, 0, 0);
        run_txn(0, 32'h88, 64'h0123_4567_89AB_CDEF, 8'h00, 1, 0, 2, 2'b01, 64'h0123_4567_89AB_CDEF, 5, 0);
        run_txn(1, 32'h90, 64'h1, 8'h01, 2, 0, 1, 2'b11, 64'h0, 0, 0);

        // Reset while both write channels are stalled.
        i_awready = 0; i_wready = 0;
        i_req_valid = 1; i_req_write = 1; i_req_addr = 32'hC0; i_req_wdata = 64'h55; i_req_wstrb = 8'h3;
        @(negedge i_clk);
        i_req_valid = 0;
        chk("pre_rst_awvalid", o_awvalid, 1'b1);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("mid_rst_valids", {o_awvalid, o_wvalid, o_arvalid, o_rsp_valid}, 4'b0);
        chk("mid_rst_idle", o_idle, 1'b1);
        chk("mid_rst_req_ready", o_req_ready, 1'b1);
        i_rst = 1'b0;
        i_awready = 1; i_wready = 1; i_bvalid = 1; i_rvalid = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            chk("post_rst_quiet", {o_rsp_valid, o_awvalid, o_wvalid, o_bready, o_rready}, 5'b0);
            chk("post_rst_idle", o_idle, 1'b1);
        end
        i_awready = 0; i_wready = 0; i_bvalid = 0; i_rvalid = 0;

        // Randomized traffic with idle gaps.
        for (int n = 0; n < 150; n++) begin
            int gap;
            run_txn(1'($urandom), $urandom, {$urandom, $urandom}, 8'($urandom),
                    int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), int'($urandom_range(0, 4)),
                    2'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 3)), 0);
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                @(negedge i_clk);
                chk("gap_idle", o_idle, 1'b1);
            end
        end

`ifdef PT_AXI4LITE_INIT_ERR_CNT_EN
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        model_err_cnt = 0;
        @(negedge i_clk);
        for (int n = 0; n < 300; n++)
            run_txn(1'(n & 1), 32'(n * 8), 64'(n), 8'hFF, 0, 0, 0, 2'b10, 64'(n), 0, 0);
        chk("err_sat_literal", o_err_count, 8'd255);
        run_txn(0, 32'h100, 64'h0, 8'h00, 0, 0, 0, 2'b11, 64'h77, 0, 1);
        chk("err_clear_literal", o_err_count, 8'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
